// File: rtl/reg_scoreboard_pkg.sv
// Register-id map shared by the issue scoreboard and its per-entry counters.
package reg_scoreboard_pkg;

    typedef logic [7:0] reg_id_t;

    localparam int unsigned REG_FILE_SIZE = 20;
    localparam int unsigned FLAGS_IDX     = 16;
    localparam int unsigned SB_CNT_W      = 2;
    localparam int unsigned SB_IDX_W      = 5;

    typedef logic [SB_CNT_W-1:0] sb_cnt_t;

    localparam reg_id_t REG_FILE_BASE = 8'h80;

    // Real register-file entries
    localparam reg_id_t RAX    = 8'h80;
    localparam reg_id_t RCX    = 8'h81;
    localparam reg_id_t RDX    = 8'h82;
    localparam reg_id_t RBX    = 8'h83;
    localparam reg_id_t RSP    = 8'h84;
    localparam reg_id_t RBP    = 8'h85;
    localparam reg_id_t RSI    = 8'h86;
    localparam reg_id_t RDI    = 8'h87;
    localparam reg_id_t RFLAGS = 8'h90;
    localparam reg_id_t RHA    = 8'h91;
    localparam reg_id_t RHB    = 8'h92;
    localparam reg_id_t RHC    = 8'h93;

    // Pseudo registers that never live in the register file
    localparam reg_id_t RNIL     = 8'h00;
    localparam reg_id_t RIP      = 8'h01;
    localparam reg_id_t RIMM     = 8'h02;
    localparam reg_id_t RSYSCALL = 8'h03;
    localparam reg_id_t RV0      = 8'h40;
    localparam reg_id_t RV8      = 8'h48;

    // True when the id names a real register-file entry
    function automatic logic reg_in_file(input reg_id_t id);
        return (id >= REG_FILE_BASE) && (id < (REG_FILE_BASE + 8'(REG_FILE_SIZE)));
    endfunction

    // Entry index of a register-file id (only meaningful when reg_in_file)
    function automatic logic [SB_IDX_W-1:0] reg_num(input reg_id_t id);
        return SB_IDX_W'(id - REG_FILE_BASE);
    endfunction

endpackage

// File: rtl/reg_scoreboard_entry.sv
// One outstanding-write counter: +inc, -dec0, -dec1 per cycle, clamped at zero.
module sb_entry
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_W = SB_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec0,
    input  logic             dec1,
    input  logic             flush,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             full,
    output logic             underflow
);

    localparam int unsigned SUM_W = CNT_W + 2;

    logic [SUM_W-1:0] up;
    logic [SUM_W-1:0] down;
    logic [CNT_W-1:0] cnt_nxt;

    // Net update; a flush discards everything and never reports underflow
    always_comb begin
        up        = SUM_W'(cnt) + SUM_W'(inc);
        down      = SUM_W'(dec0) + SUM_W'(dec1);
        underflow = 1'b0;
        cnt_nxt   = cnt;
        if (flush) begin
            cnt_nxt = '0;
        end else if (down > up) begin
            underflow = 1'b1;
            cnt_nxt   = '0;
        end else begin
            cnt_nxt = CNT_W'(up - down);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    assign busy = |cnt;
    assign full = &cnt;

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-gating scoreboard: tracks in-flight writes per register-file entry.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_W       = SB_CNT_W,
    parameter int unsigned NUM_ENTRIES = REG_FILE_SIZE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  reg_id_t                src_a,
    input  reg_id_t                src_b,
    input  reg_id_t                dst,
    input  logic                   rd_flags,
    input  logic                   wr_flags,
    input  logic                   wb0_valid,
    input  reg_id_t                wb0_reg,
    input  logic                   wb0_flags,
    input  logic                   wb1_valid,
    input  reg_id_t                wb1_reg,
    input  logic                   wb1_flags,
    output logic [NUM_ENTRIES-1:0] busy_vec,
    output logic                   idle,
    output logic                   err
);

    logic                   fire;
    logic [NUM_ENTRIES-1:0] inc_vec;
    logic [NUM_ENTRIES-1:0] dec0_vec;
    logic [NUM_ENTRIES-1:0] dec1_vec;
    logic [NUM_ENTRIES-1:0] full_vec;
    logic [NUM_ENTRIES-1:0] uf_vec;
    logic [NUM_ENTRIES-1:0] zero_vec;
    logic [CNT_W-1:0]       cnt_arr [NUM_ENTRIES];

    // Hazard check from registered counters only; no writeback bypass
    always_comb begin
        issue_ready = ~flush;
        if (reg_in_file(src_a) && busy_vec[reg_num(src_a)]) issue_ready = 1'b0;
        if (reg_in_file(src_b) && busy_vec[reg_num(src_b)]) issue_ready = 1'b0;
        if (rd_flags && busy_vec[FLAGS_IDX])                issue_ready = 1'b0;
        if (reg_in_file(dst) && full_vec[reg_num(dst)])     issue_ready = 1'b0;
        if (wr_flags && full_vec[FLAGS_IDX])                issue_ready = 1'b0;
    end

    assign fire = issue_valid & issue_ready;

    // One-hot increment/decrement decode; dst==rflags with wr_flags merges into one +1
    always_comb begin
        inc_vec  = '0;
        dec0_vec = '0;
        dec1_vec = '0;
        for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
            if (fire && reg_in_file(dst) && (reg_num(dst) == SB_IDX_W'(i)))         inc_vec[i]  = 1'b1;
            if (wb0_valid && reg_in_file(wb0_reg) && (reg_num(wb0_reg) == SB_IDX_W'(i))) dec0_vec[i] = 1'b1;
            if (wb1_valid && reg_in_file(wb1_reg) && (reg_num(wb1_reg) == SB_IDX_W'(i))) dec1_vec[i] = 1'b1;
        end
        if (fire && wr_flags) inc_vec[FLAGS_IDX]  = 1'b1;
        if (wb0_flags)        dec0_vec[FLAGS_IDX] = 1'b1;
        if (wb1_flags)        dec1_vec[FLAGS_IDX] = 1'b1;
    end

    // Per-entry counters
    for (genvar g = 0; g < int'(NUM_ENTRIES); g++) begin : g_entry
        sb_entry #(
            .CNT_W (CNT_W)
        ) u_entry (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc_vec[g]),
            .dec0      (dec0_vec[g]),
            .dec1      (dec1_vec[g]),
            .flush     (flush),
            .cnt       (cnt_arr[g]),
            .busy      (busy_vec[g]),
            .full      (full_vec[g]),
            .underflow (uf_vec[g])
        );
        assign zero_vec[g] = (cnt_arr[g] == '0);
    end

    assign idle = &zero_vec;

    // Sticky error: any counter underflow since reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (|uf_vec) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with a reference counter model and expectation queues.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    localparam int N    = REG_FILE_SIZE;
    localparam int MAXC = (1 << SB_CNT_W) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          issue_valid;
    logic          issue_ready;
    reg_id_t       src_a, src_b, dst;
    logic          rd_flags, wr_flags;
    logic          wb0_valid, wb0_flags, wb1_valid, wb1_flags;
    reg_id_t       wb0_reg, wb1_reg;
    logic [N-1:0]  busy_vec;
    logic          idle;
    logic          err;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .src_a       (src_a),
        .src_b       (src_b),
        .dst         (dst),
        .rd_flags    (rd_flags),
        .wr_flags    (wr_flags),
        .wb0_valid   (wb0_valid),
        .wb0_reg     (wb0_reg),
        .wb0_flags   (wb0_flags),
        .wb1_valid   (wb1_valid),
        .wb1_reg     (wb1_reg),
        .wb1_flags   (wb1_flags),
        .busy_vec    (busy_vec),
        .idle        (idle),
        .err         (err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_cnt [N];
    bit m_err = 1'b0;

    // Expectations queued at drive time, consumed after the edge
    logic [N-1:0] q_busy [$];
    bit           q_err  [$];
    string        q_tag  [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit trk(input reg_id_t id);
        return (id >= 8'h80) && (id <= 8'h93);
    endfunction

    function automatic int idx(input reg_id_t id);
        return int'(id) - 128;
    endfunction

    function automatic bit m_ready();
        if (flush) return 1'b0;
        if (trk(src_a) && m_cnt[idx(src_a)] != 0) return 1'b0;
        if (trk(src_b) && m_cnt[idx(src_b)] != 0) return 1'b0;
        if (rd_flags && m_cnt[FLAGS_IDX] != 0) return 1'b0;
        if (trk(dst) && m_cnt[idx(dst)] == MAXC) return 1'b0;
        if (wr_flags && m_cnt[FLAGS_IDX] == MAXC) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [N-1:0] m_busy();
        logic [N-1:0] b;
        b = '0;
        for (int i = 0; i < N; i++) b[i] = (m_cnt[i] != 0);
        return b;
    endfunction

    task automatic clr();
        flush       = 1'b0;
        issue_valid = 1'b0;
        src_a       = RNIL;
        src_b       = RNIL;
        dst         = RNIL;
        rd_flags    = 1'b0;
        wr_flags    = 1'b0;
        wb0_valid   = 1'b0;
        wb0_reg     = RNIL;
        wb0_flags   = 1'b0;
        wb1_valid   = 1'b0;
        wb1_reg     = RNIL;
        wb1_flags   = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_err = 1'b0;
    endtask

    // Check ready, advance the model, clock once, compare queued expectations
    task automatic tick(input string tag);
        int           inc [N];
        int           d0  [N];
        int           d1  [N];
        int           v;
        bit           rdy;
        bit           uf;
        logic [N-1:0] eb;
        bit           ee;
        string        et;
        #1;
        rdy = m_ready();
        check({tag, "/ready"}, 32'(issue_ready), 32'(rdy));
        for (int i = 0; i < N; i++) begin
            inc[i] = 0; d0[i] = 0; d1[i] = 0;
        end
        if (issue_valid && rdy) begin
            if (trk(dst)) inc[idx(dst)] = 1;
            if (wr_flags) inc[FLAGS_IDX] = 1;
        end
        if (wb0_valid && trk(wb0_reg)) d0[idx(wb0_reg)] = 1;
        if (wb0_flags) d0[FLAGS_IDX] = 1;
        if (wb1_valid && trk(wb1_reg)) d1[idx(wb1_reg)] = 1;
        if (wb1_flags) d1[FLAGS_IDX] = 1;
        uf = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (flush) begin
                m_cnt[i] = 0;
            end else begin
                v = m_cnt[i] + inc[i] - d0[i] - d1[i];
                if (v < 0) begin
                    v  = 0;
                    uf = 1'b1;
                end
                m_cnt[i] = v;
            end
        end
        if (uf) m_err = 1'b1;
        q_busy.push_back(m_busy());
        q_err.push_back(m_err);
        q_tag.push_back(tag);
        @(posedge clk);
        #1;
        eb = q_busy.pop_front();
        ee = q_err.pop_front();
        et = q_tag.pop_front();
        check({et, "/busy"}, 32'(busy_vec), 32'(eb));
        check({et, "/idle"}, 32'(idle), 32'(eb == '0));
        check({et, "/err"},  32'(err), 32'(ee));
    endtask

    initial begin
        reset = 1'b1;
        clr();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("reset/busy",  32'(busy_vec), 32'h0);
        check("reset/idle",  32'(idle), 32'h1);
        check("reset/ready", 32'(issue_ready), 32'h1);
        check("reset/err",   32'(err), 32'h0);

        // 1: RAW on rax, released one cycle after writeback
        clr(); issue_valid = 1'b1; dst = RAX; tick("t1_iss_rax");
        check("t1_busy0", 32'(busy_vec[0]), 32'h1);
        clr(); issue_valid = 1'b1; src_a = RAX; #1;
        check("t1_raw_block", 32'(issue_ready), 32'h0);
        tick("t1_blocked");
        clr(); wb0_valid = 1'b1; wb0_reg = RAX; tick("t1_wb_rax");
        clr(); issue_valid = 1'b1; src_a = RAX; #1;
        check("t1_raw_release", 32'(issue_ready), 32'h1);
        tick("t1_dep_issue");

        // 2: pseudo registers are never tracked
        clr(); issue_valid = 1'b1; dst = RSP; tick("t2_iss_rsp");
        clr(); issue_valid = 1'b1; src_a = RIMM; src_b = RIP; dst = RNIL; #1;
        check("t2_fake_ready", 32'(issue_ready), 32'h1);
        tick("t2_fake_issue");
        check("t2_busy_same", 32'(busy_vec), 32'h10);
        clr(); wb0_valid = 1'b1; wb0_reg = RV8; tick("t2_wb_rv8");
        check("t2_no_err", 32'(err), 32'h0);
        clr(); wb1_valid = 1'b1; wb1_reg = RSP; tick("t2_wb_rsp");

        // 3: rcx saturates at 3 in flight, dual retire in one cycle
        clr(); issue_valid = 1'b1; dst = RCX; tick("t3_iss1");
        clr(); issue_valid = 1'b1; dst = RCX; tick("t3_iss2");
        clr(); issue_valid = 1'b1; dst = RCX; tick("t3_iss3");
        clr(); issue_valid = 1'b1; dst = RCX;
        wb0_valid = 1'b1; wb0_reg = RCX; wb1_valid = 1'b1; wb1_reg = RCX; #1;
        check("t3_full_block", 32'(issue_ready), 32'h0);
        tick("t3_dual_wb");
        check("t3_busy1", 32'(busy_vec[1]), 32'h1);
        clr(); wb0_valid = 1'b1; wb0_reg = RCX; tick("t3_drain");
        check("t3_busy1_clear", 32'(busy_vec[1]), 32'h0);

        // 4: issue and retire the same entry in one cycle nets to zero change
        clr(); issue_valid = 1'b1; dst = RDX; tick("t4_iss");
        clr(); issue_valid = 1'b1; dst = RDX; wb0_valid = 1'b1; wb0_reg = RDX; tick("t4_iss_wb");
        check("t4_still_busy", 32'(busy_vec[2]), 32'h1);
        clr(); wb1_valid = 1'b1; wb1_reg = RDX; tick("t4_wb1");
        check("t4_idle", 32'(idle), 32'h1);

        // 5: flags hazard, and dst=rflags with wr_flags counts once
        clr(); issue_valid = 1'b1; wr_flags = 1'b1; tick("t5_wrf");
        check("t5_flags_busy", 32'(busy_vec[FLAGS_IDX]), 32'h1);
        clr(); issue_valid = 1'b1; rd_flags = 1'b1; #1;
        check("t5_rdf_block", 32'(issue_ready), 32'h0);
        tick("t5_rdf_blocked");
        clr(); wb1_valid = 1'b1; wb1_reg = RNIL; wb1_flags = 1'b1; tick("t5_wbf");
        clr(); issue_valid = 1'b1; rd_flags = 1'b1; #1;
        check("t5_rdf_release", 32'(issue_ready), 32'h1);
        tick("t5_rdf_issue");
        clr(); issue_valid = 1'b1; dst = RFLAGS; wr_flags = 1'b1; tick("t5_dst_flags");
        clr(); wb0_valid = 1'b1; wb0_reg = RNIL; wb0_flags = 1'b1; tick("t5_single_retire");
        check("t5_once_idle", 32'(idle), 32'h1);

        // 6: flush squashes everything, then underflow raises sticky err
        clr(); issue_valid = 1'b1; dst = RAX; tick("t6_iss_rax");
        clr(); issue_valid = 1'b1; dst = RDI; tick("t6_iss_rdi");
        clr(); issue_valid = 1'b1; dst = RAX; flush = 1'b1; wb0_valid = 1'b1; wb0_reg = RDI; #1;
        check("t6_flush_block", 32'(issue_ready), 32'h0);
        tick("t6_flush");
        check("t6_flush_clear", 32'(busy_vec), 32'h0);
        check("t6_flush_noerr", 32'(err), 32'h0);
        clr(); wb0_valid = 1'b1; wb0_reg = RBX; tick("t6_underflow");
        check("t6_err_set", 32'(err), 32'h1);
        clr(); tick("t6_err_hold");
        check("t6_err_sticky", 32'(err), 32'h1);
        clr(); issue_valid = 1'b1; dst = RHC; tick("t6_iss_rhc");
        check("t6_rhc_busy", 32'(busy_vec[19]), 32'h1);

        // Asynchronous reset between edges
        clr();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("t6_rst_err",  32'(err), 32'h0);
        check("t6_rst_idle", 32'(idle), 32'h1);
        check("t6_rst_busy", 32'(busy_vec), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        clr(); issue_valid = 1'b1; dst = RBX; tick("t6_post_reset");
        check("t6_post_busy3", 32'(busy_vec[3]), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks outstanding writes to every real register-file entry (rax..rhc, REG_FILE_SIZE = 20 entries, including rflags) and gates instruction issue on RAW/WAW-overflow hazards.
- Sits between decode/issue and the register file.
- Issue sets pending writes; up to two writeback ports retire them.
- Fake registers (rnil, rip, rimm, rsyscall, rv0, rv8) are never tracked and never stall.

Parameters:
- CNT_W, 2, width of each per-entry outstanding-write counter (max 2^CNT_W-1 in flight per entry).
- NUM_ENTRIES, REG_FILE_SIZE (20), number of tracked entries, indexed by reg_num().
- FLAGS_IDX, 16, entry index of rflags.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all counters (pipeline squash).
- issue_valid  in  1  decode presents an instruction.
- issue_ready  out  1  no hazard; instruction may issue this cycle.
- src_a  in  8  reg_id_t, first source.
- src_b  in  8  reg_id_t, second source.
- dst  in  8  reg_id_t, destination (rnil = none).
- rd_flags  in  1  instruction reads rflags.
- wr_flags  in  1  instruction writes rflags.
- wb0_valid  in  1  writeback port 0 retires a write.
- wb0_reg  in  8  reg_id_t retired on port 0.
- wb0_flags  in  1  port 0 also retires a flags write.
- wb1_valid  in  1  writeback port 1 retires a write.
- wb1_reg  in  8  reg_id_t retired on port 1.
- wb1_flags  in  1  port 1 also retires a flags write.
- busy_vec  out  NUM_ENTRIES  bit i = counter i nonzero.
- idle  out  1  all counters zero.
- err  out  1  sticky error flag.

Behaviour:
- Reset (async): all counters 0, err 0. Hence busy_vec 0, idle 1, issue_ready 1.
- Tracking: a reg_id_t is tracked iff reg_in_file(id) (0x80..0x93). Entry index = reg_num(id). Untracked ids are ignored on every port.
- issue_ready is combinational from registered counters only; there is no same-cycle bypass from writeback. It is 0 if any of the following holds:
  - a tracked src_a or src_b counter is nonzero;
  - rd_flags and the rflags counter is nonzero;
  - a tracked dst counter is at max;
  - wr_flags and the rflags counter is at max;
  - flush is 1.
- issue_ready does not depend on issue_valid.
- Issue fires when issue_valid & issue_ready. On fire:
  - the tracked dst counter +1;
  - if wr_flags, the rflags counter +1;
  - if dst is rflags and wr_flags, the counter gets +1 only once.
- Writeback: each wbN_valid decrements the counter for a tracked wbN_reg by 1. wbN_flags decrements rflags by 1.
- Net update per entry = increments − decrements, applied at the next edge. Issue and two writebacks to the same entry in one cycle give net −1. Both ports retiring the same entry give −2.
- Underflow: a decrement that would take a counter below 0 clamps it at 0 and sets err. err stays set until reset.
- Overflow cannot occur because issue is blocked at max.
- flush: at the edge all counters go to 0. Issue and writebacks in the same cycle are discarded, and no err is raised.
- Latency: issue at cycle t makes busy visible at t+1. Writeback at t clears at t+1, so a dependent instruction issues at t+1 at the earliest.
- busy_vec and idle are combinational from the counters.

Decomposition:
- RegMap package (shared):
  - reg_id_t, REG_FILE_SIZE, reg_in_file, reg_num;
  - new constants FLAGS_IDX and SB_CNT_W;
  - new typedef sb_cnt_t = logic[SB_CNT_W-1:0].
- Sub-module sb_entry: one counter, with inputs inc, dec0, dec1, flush, and outputs cnt, busy, full, underflow. Instantiated NUM_ENTRIES times via generate.
- Top module: decodes ids to one-hot inc/dec vectors, computes hazards, and ORs the underflow outputs into err.

Test Plan:
1. After reset: issue dst=rax (0x80) → busy_vec[0]=1 next cycle. Then issue with src_a=rax → issue_ready=0. Then wb0_reg=rax → ready=1 one cycle later.
2. src_a=rimm, src_b=rip, dst=rnil with any busy state → issue_ready=1. busy_vec unchanged; a writeback to rv8 → no change, err=0.
3. Issue dst=rcx three times (CNT_W=2) → counter 3, fourth issue to rcx blocked. In the same cycle, wb0 and wb1 both retire rcx → counter 1, busy_vec[1]=1.
4. Same cycle: issue dst=rdx while wb0_reg=rdx with the counter at 1 → counter stays 1. Next cycle wb1_reg=rdx → counter 0, idle=1.
5. Issue wr_flags=1 → busy_vec[16]=1. Next issue with rd_flags=1 → blocked. Then wb1_flags=1 → unblocked.
6. With counters nonzero, assert flush together with issue_valid → issue_ready=0, all counters 0 next cycle. Then wb0_reg=rbx at zero → err=1, stays 1. Asserting reset mid-sequence → err=0, idle=1 immediately.
